// File: rtl/closed_loop_synchronizer_arbiter.sv
// Source-domain round-robin arbiter sharing one closed-loop vector synchronizer.
// A winner's data is launched into the synchronizer. The arbiter then follows the
// synchronizer's busy rise/fall handshake and pulses ready back to the winner.
module closed_loop_synchronizer_arbiter #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned REQUESTERS  = 4,
   parameter int unsigned INDEX_WIDTH = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [REQUESTERS-1:0]        request_valid,
   input  logic [REQUESTERS*WIDTH-1:0]  request_data,
   output logic [REQUESTERS-1:0]        request_ready,
   output logic [WIDTH-1:0]             synchronizer_data,
   input  logic                         synchronizer_busy,
   output logic [INDEX_WIDTH-1:0]       grant_index,
   output logic                         transfer_active
);

   typedef enum logic [1:0] {
      StIdle,
      StWaitRise,
      StWaitFall,
      StDone
   } state_e;

   localparam logic [INDEX_WIDTH-1:0] LastIndex = INDEX_WIDTH'(REQUESTERS - 1);

   state_e                    state_q, state_d;
   logic [INDEX_WIDTH-1:0]    pointer_q, pointer_d;
   logic [INDEX_WIDTH-1:0]    grant_q, grant_d;
   // Also serves as last_sent: both are loaded together and share a reset value.
   logic [WIDTH-1:0]          sync_data_q, sync_data_d;
   logic [REQUESTERS-1:0]     ready_q, ready_d;

   logic [WIDTH-1:0]          client_data [REQUESTERS];
   logic [INDEX_WIDTH-1:0]    winner_index;
   logic                      winner_found;
   logic [WIDTH-1:0]          winner_data;
   logic                      grant_now;
   logic                      data_differs;

   // Unpack the flat client data bus into one word per client.
   for (genvar i = 0; i < REQUESTERS; i++) begin : g_unpack
      assign client_data[i] = request_data[i*WIDTH +: WIDTH];
   end

   // Search upward from pointer+1, wrapping, for the first valid client.
   always_comb begin
      logic [INDEX_WIDTH-1:0] candidate;
      winner_found = 1'b0;
      winner_index = '0;
      candidate    = pointer_q;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (candidate == LastIndex) begin
            candidate = '0;
         end else begin
            candidate = candidate + INDEX_WIDTH'(1);
         end
         if (!winner_found && request_valid[candidate]) begin
            winner_found = 1'b1;
            winner_index = candidate;
         end
      end
   end

   assign winner_data  = client_data[winner_index];
   // Busy holds off new grants so a still-running handshake is never disturbed.
   assign grant_now    = (state_q == StIdle) && winner_found && !synchronizer_busy;
   // Resending the current value would not toggle busy, so that case skips the wait.
   assign data_differs = (winner_data != sync_data_q);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic following the busy rise/fall handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (grant_now) begin
               state_d = data_differs ? StWaitRise : StDone;
            end
         end
         StWaitRise: begin
            if (synchronizer_busy) begin
               state_d = StWaitFall;
            end
         end
         StWaitFall: begin
            if (!synchronizer_busy) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output and datapath next values; ready is decoded from the next state so it is registered.
   always_comb begin
      pointer_d   = pointer_q;
      grant_d     = grant_q;
      sync_data_d = sync_data_q;
      ready_d     = '0;
      if (grant_now) begin
         pointer_d = winner_index;
         grant_d   = winner_index;
         if (data_differs) begin
            sync_data_d = winner_data;
         end
      end
      if (state_d == StDone) begin
         ready_d[grant_d] = 1'b1;
      end
   end

   // Datapath registers; pointer resets to the last client so client 0 wins first.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pointer_q   <= LastIndex;
         grant_q     <= '0;
         sync_data_q <= '0;
         ready_q     <= '0;
      end else begin
         pointer_q   <= pointer_d;
         grant_q     <= grant_d;
         sync_data_q <= sync_data_d;
         ready_q     <= ready_d;
      end
   end

   assign request_ready     = ready_q;
   assign synchronizer_data = sync_data_q;
   assign grant_index       = grant_q;
   assign transfer_active   = (state_q != StIdle);

endmodule

// File: doc/closed_loop_synchronizer_arbiter.md
Name: closed_loop_synchronizer_arbiter

Overview:
Source-domain arbiter that shares one closed-loop vector synchronizer among REQUESTERS clients.
- Grants requests round-robin and drives the synchronizer data input.
- Waits for the busy handshake to complete, then acknowledges the winning requester.
- Runs entirely on the source clock. It sits between the source-side clients and the synchronizer's data_in/busy ports.

Parameters:
WIDTH, 8, data width of each request and of the synchronizer.
REQUESTERS, 4, number of clients (≥2).
INDEX_WIDTH, max(1,$clog2(REQUESTERS)), width of the grant index.

Ports:
clock  input  1  source-domain clock.
reset  input  1  asynchronous, active-high reset.
request_valid  input  REQUESTERS  per-client request; held high with stable data until the matching request_ready.
request_data  input  REQUESTERS*WIDTH  packed client data; client i occupies bits [i*WIDTH +: WIDTH].
request_ready  output  REQUESTERS  one-cycle completion pulse to the granted client.
synchronizer_data  output  WIDTH  registered; drives synchronizer data_in.
synchronizer_busy  input  1  synchronizer busy flag.
grant_index  output  INDEX_WIDTH  index of the current or most recent grant.
transfer_active  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: request_ready=0, synchronizer_data=0, grant_index=0, transfer_active=0, state=IDLE, round-robin pointer=REQUESTERS-1, last_sent=0.
- FSM states: IDLE, WAIT_RISE, WAIT_FALL, DONE.
- IDLE behaviour:
  - If any request_valid is high and synchronizer_busy=0, pick the first valid index searching upward from pointer+1, wrapping modulo REQUESTERS.
  - Register grant_index and set pointer=winner.
  - If request_data[winner] != last_sent: load synchronizer_data and last_sent with it, go to WAIT_RISE.
  - If request_data[winner] == last_sent: the synchronizer would not raise busy, so go straight to DONE and leave synchronizer_data unchanged.
- If synchronizer_busy=1 in IDLE, no grant is made. Requests wait.
- WAIT_RISE: stay until synchronizer_busy=1, then go to WAIT_FALL.
- WAIT_FALL: stay until synchronizer_busy=0, then go to DONE.
- DONE:
  - request_ready[grant_index]=1 for exactly this one cycle; all other ready bits stay 0.
  - Next state is IDLE.
- Minimum spacing between grants is 2 cycles (DONE then IDLE). No grant is made from DONE.
- request_ready is registered, so it asserts the cycle after busy-fall is sampled.
- Latency from request_valid to synchronizer_data update is 1 cycle, when IDLE and busy=0.
- Requests are never dropped or preempted.
- A request_valid deasserted before its ready is a protocol violation. The arbiter still completes the transfer already in flight and pulses ready.
- Round-robin guarantee: with all clients continuously requesting, grants go 0,1,2,...,REQUESTERS-1,0,...
- A single requester may be granted back-to-back.
- transfer_active = (state != IDLE).
- Reset mid-transfer: all state returns to reset values immediately and no ready pulse is issued. The synchronizer is reset in the same operation, so last_sent=0 matches its reset output.

Test Plan:
- Reset, then client 2 requests 8'hA5 with busy modelled (rise 2 cycles after data change, fall 6 cycles later) -> synchronizer_data=A5 one cycle after the grant, grant_index=2, single request_ready[2] pulse one cycle after busy falls, transfer_active high exactly over that span.
- Clients 0 and 1 request 8'h11 and 8'h22 on the same cycle after reset -> client 0 served first, then 1. Two ready pulses in order; synchronizer_data sequence 11, 22.
- All 4 clients continuously request distinct values for 12 transfers -> grant_index sequence 0,1,2,3,0,1,2,3,0,1,2,3, no client starved, no ready overlap.
- Client 3 sends 8'h5C, then client 3 sends 8'h5C again -> second grant goes IDLE→DONE with no data change and no busy wait. request_ready[3] pulses 2 cycles after its valid.
- Hold synchronizer_busy=1 while client 1 requests -> no grant and transfer_active=0. Release busy -> grant on the next edge.
- Assert reset while in WAIT_FALL with client 0 granted -> all outputs return to 0 asynchronously and no request_ready pulse. After release, the pending client 0 request is regranted and completes normally.
- Concurrently, across all scenarios, check `$onehot0(request_ready)` every cycle.
